mips_cpu_muldiv_ctrl: RTL and testbench

//  Multi-cycle sequencer for MIPS MULT/MULTU/DIV/DIVU and owner of the architectural HI/LO registers.

---
 rtl/mips_cpu_pkg.sv | 20 ++
 rtl/mips_cpu_muldiv_step.sv | 36 +++
 rtl/mips_cpu_muldiv_ctrl.sv | 161 ++++++++++++++++
 tb/tb_mips_cpu_muldiv_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_cpu_pkg.sv
// Shared types for the MIPS CPU multiply/divide sequencer.
// The op encoding is what decode drives onto the muldiv op port.
package mips_cpu_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } muldiv_op_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_ITER = 2'd1,
    MD_FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/mips_cpu_muldiv_step.sv
// One radix-2 iteration on the {acc_hi, acc_lo} pair.
// Multiply: shift-add, multiplier LSB first. Divide: restoring shift-subtract.
module mips_cpu_muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc_hi_i,
  input  logic [WIDTH-1:0] acc_lo_i,
  input  logic [WIDTH-1:0] opnd_i,
  output logic [WIDTH-1:0] acc_hi_o,
  output logic [WIDTH-1:0] acc_lo_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_sub;
  logic             no_borrow;

  always_comb begin
    sum       = {1'b0, acc_hi_i} + (acc_lo_i[0] ? {1'b0, opnd_i} : '0);
    rem_sh    = {acc_hi_i, acc_lo_i[WIDTH-1]};
    no_borrow = (rem_sh >= {1'b0, opnd_i});
    // The difference is below the divisor whenever it is kept, so WIDTH bits suffice.
    rem_sub   = rem_sh[WIDTH-1:0] - opnd_i;
    acc_hi_o  = '0;
    acc_lo_o  = '0;
    if (is_div) begin
      acc_hi_o = no_borrow ? rem_sub : rem_sh[WIDTH-1:0];
      acc_lo_o = {acc_lo_i[WIDTH-2:0], no_borrow};
    end else begin
      acc_hi_o = sum[WIDTH:1];
      acc_lo_o = {sum[0], acc_lo_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mips_cpu_muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer and owner of HI/LO.
// Handshake: start is sampled only while busy=0; a start seen while busy=1 is dropped.
module mips_cpu_muldiv_ctrl
  import mips_cpu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  muldiv_op_t       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output state_t           state_dbg
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               is_div_q, is_div_d;
  logic               sign_q_q, sign_q_d, sign_r_q, sign_r_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d, div_zero_q, div_zero_d;

  logic [WIDTH-1:0]   step_hi, step_lo;
  logic               signed_op;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  mips_cpu_muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (is_div_q),
    .acc_hi_i (acc_hi_q),
    .acc_lo_i (acc_lo_q),
    .opnd_i   (opnd_q),
    .acc_hi_o (step_hi),
    .acc_lo_o (step_lo)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    opnd_d     = opnd_q;
    is_div_d   = is_div_q;
    sign_q_d   = sign_q_q;
    sign_r_d   = sign_r_q;
    dz_d       = dz_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;

    signed_op = (op == MD_MULT) || (op == MD_DIV);
    abs_a     = (signed_op && a[WIDTH-1]) ? -a : a;
    abs_b     = (signed_op && b[WIDTH-1]) ? -b : b;

    prod_fix  = sign_q_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
    quot_fix  = sign_q_q ? -acc_lo_q : acc_lo_q;
    rem_fix   = sign_r_q ? -acc_hi_q : acc_hi_q;

    if (abort) begin
      state_d = MD_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (start) begin
            case (op)
              MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                is_div_d = (op == MD_DIV) || (op == MD_DIVU);
                // Divide shifts the dividend out of acc_lo; multiply shifts the multiplier out.
                acc_hi_d = '0;
                acc_lo_d = is_div_d ? abs_a : abs_b;
                opnd_d   = is_div_d ? abs_b : abs_a;
                sign_q_d = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                sign_r_d = signed_op & a[WIDTH-1];
                dz_d     = (b == '0);
                cnt_d    = '0;
                state_d  = MD_ITER;
              end
              MD_MTHI: hi_d = a;
              MD_MTLO: lo_d = a;
              default: ;
            endcase
          end
        end
        MD_ITER: begin
          acc_hi_d = step_hi;
          acc_lo_d = step_lo;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = MD_FIX;
        end
        MD_FIX: begin
          if (is_div_q) begin
            // Remainder of x/0 already equals |a|; only the quotient needs forcing.
            hi_d       = rem_fix;
            lo_d       = dz_q ? '1 : quot_fix;
            div_zero_d = dz_q;
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = MD_IDLE;
        end
        default: state_d = MD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= MD_IDLE;
      cnt_q      <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      opnd_q     <= '0;
      is_div_q   <= 1'b0;
      sign_q_q   <= 1'b0;
      sign_r_q   <= 1'b0;
      dz_q       <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      opnd_q     <= opnd_d;
      is_div_q   <= is_div_d;
      sign_q_q   <= sign_q_d;
      sign_r_q   <= sign_r_d;
      dz_q       <= dz_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy      = (state_q != MD_IDLE);
  assign done      = done_q;
  assign div_zero  = div_zero_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_mips_cpu_muldiv_ctrl.sv
// Directed bench for mips_cpu_muldiv_ctrl: hand-computed HI/LO results,
// latency, busy/done timing, abort, back-to-back issue and async reset.
module tb_mips_cpu_muldiv_ctrl;
  import mips_cpu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  muldiv_op_t  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        abort;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;
  state_t      state_dbg;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] exp_q[$];

  mips_cpu_muldiv_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero),
    .hi        (hi),
    .lo        (lo),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive at a negedge; returns at the first negedge after the issuing edge (cycle 1).
  task automatic start_op(input muldiv_op_t o, input logic [31:0] av, input logic [31:0] bv);
    op    = o;
    a     = av;
    b     = bv;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at the negedge of cycle n0 after the issuing edge.
  task automatic wait_done(input string tag, input int n0, input logic exp_dz);
    int n;
    bit seen;
    bit busy_ok;
    logic [63:0] exp;
    n = n0;
    seen = 0;
    busy_ok = 1;
    while (n <= 40 && !seen) begin
      if (done) seen = 1;
      else begin
        if (!busy) busy_ok = 0;
        @(negedge clk);
        n++;
      end
    end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    check({tag, "_latency"}, 64'(n), 64'd34);
    check({tag, "_busy_held"}, 64'(busy_ok), 64'd1);
    check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    check({tag, "_hilo"}, {hi, lo}, exp);
    check({tag, "_div_zero"}, 64'(div_zero), 64'(exp_dz));
  endtask

  task automatic run_op(input string tag, input muldiv_op_t o, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] eh, input logic [31:0] el,
                        input logic edz);
    exp_q.push_back({eh, el});
    start_op(o, av, bv);
    wait_done(tag, 1, edz);
  endtask

  initial begin
    bit saw_done;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    op    = MD_MULT;
    a     = '0;
    b     = '0;

    // reset state
    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_div_zero", 64'(div_zero), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_state", 64'(state_dbg), 64'(MD_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // MTLO / MTHI: single cycle, no busy, no done
    start_op(MD_MTLO, 32'h0000_1234, 32'h0);
    check("mtlo_lo", 64'(lo), 64'h1234);
    check("mtlo_busy", 64'(busy), 64'd0);
    check("mtlo_done", 64'(done), 64'd0);
    start_op(MD_MTHI, 32'h0000_ABCD, 32'h0);
    check("mthi_hi", 64'(hi), 64'hABCD);
    check("mthi_lo_kept", 64'(lo), 64'h1234);
    check("mthi_busy", 64'(busy), 64'd0);

    // abort at cycle 10 of a MULT: idle next cycle, HI/LO kept, no done
    start_op(MD_MULT, 32'd5, 32'd6);
    repeat (9) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_state", 64'(state_dbg), 64'(MD_IDLE));
    saw_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) saw_done = 1;
      @(negedge clk);
    end
    check("abort_no_done", 64'(saw_done), 64'd0);
    check("abort_hilo", {hi, lo}, 64'h0000_ABCD_0000_1234);

    // abort wins over start in the same cycle
    op = MD_MTHI; a = 32'h5555_5555; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("abort_prio_hi", 64'(hi), 64'hABCD);
    check("abort_prio_busy", 64'(busy), 64'd0);

    // arithmetic vectors
    run_op("mult_neg3x7",  MD_MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run_op("multu_max",    MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op("mult_shift",   MD_MULT,  32'h1234_5678, 32'h10,       32'h0000_0001, 32'h2345_6780, 1'b0);
    run_op("div_neg7_2",   MD_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("div_7_neg2",   MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
    run_op("divu_100_7",   MD_DIVU,  32'd100,       32'd7,        32'h0000_0002, 32'h0000_000E, 1'b0);
    run_op("divu_by_zero", MD_DIVU,  32'd7,         32'd0,        32'h0000_0007, 32'hFFFF_FFFF, 1'b1);
    run_op("div_min_neg1", MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
    @(negedge clk);
    check("dz_pulse_gone", 64'(div_zero), 64'd0);
    check("done_pulse_gone", 64'(done), 64'd0);

    // back-to-back: start while busy ignored, start on the done cycle accepted
    exp_q.push_back({32'h0, 32'd15});
    start_op(MD_MULT, 32'd3, 32'd5);
    repeat (4) @(negedge clk);
    op = MD_DIVU; a = 32'd100; b = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("b2b_first", 6, 1'b0);
    run_op("b2b_second", MD_MULTU, 32'd6, 32'd7, 32'h0, 32'd42, 1'b0);
    repeat (3) @(negedge clk);
    check("b2b_idle_after", 64'(busy), 64'd0);
    check("b2b_hilo_kept", {hi, lo}, {32'h0, 32'd42});

    // asynchronous reset mid-DIV
    start_op(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    repeat (14) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_hi", 64'(hi), 64'd0);
    check("arst_lo", 64'(lo), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_state", 64'(state_dbg), 64'(MD_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
